// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Synchronous single-port data memory between the CPU memory stage and the
//   storage array. It clears the whole array after every reset, accepts
//   requests only while Busy is low, and returns read data through a
//   configurable read latency. A simultaneous read and write is a conflict:
//   the array is not accessed, Err pulses and Err_Cnt counts up to 8'hFF.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   Mem_Read  in   read request
//   Mem_Write in   write request
//   Mem_Addr  in   word address
//   M_W_Data  in   write data
//   Mem_BE    in   byte enables, bit i covers bits [8i+7:8i]
//   M_R_Data  out  read data, holds between reads
//   R_Valid   out  one-cycle pulse marking M_R_Data valid
//   Busy      out  high while requests are not accepted
//   Err       out  one-cycle pulse after a read/write conflict
//   Err_Cnt   out  saturating conflict count
module data_memory_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Mem_Read,
  input  logic                    Mem_Write,
  input  logic [ADDR_WIDTH-1:0]   Mem_Addr,
  input  logic [DATA_WIDTH-1:0]   M_W_Data,
  input  logic [DATA_WIDTH/8-1:0] Mem_BE,
  output logic [DATA_WIDTH-1:0]   M_R_Data,
  output logic                    R_Valid,
  output logic                    Busy,
  output logic                    Err,
  output logic [7:0]              Err_Cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;
  // Value of the latency counter at the edge that delivers read data.
  localparam logic [1:0]  LAT_LAST =
    2'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {INIT, IDLE, READ} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q;
  logic                    busy_q;
  logic                    rv_q;
  logic                    err_q;
  logic [7:0]              cnt_q;
  logic [1:0]              lat_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [NB-1:0]           mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Single write port shared by the clear sequencer and accepted writes.
  always_comb begin
    mem_we    = '0;
    mem_addr  = Mem_Addr;
    mem_wdata = M_W_Data;
    if (!rst) begin
      if (state_q == INIT) begin
        mem_we    = '1;
        mem_addr  = clr_ptr_q;
        mem_wdata = '0;
      end else if (!busy_q && Mem_Write && !Mem_Read) begin
        mem_we = Mem_BE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      hold_q    <= '0;
    end else begin
      rv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        INIT: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == '1) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (Mem_Read && Mem_Write) begin
            err_q <= 1'b1;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          end else if (Mem_Read) begin
            if (READ_LATENCY == 1) begin
              rv_q    <= 1'b1;
              rdata_q <= mem[Mem_Addr];
            end else begin
              // Array word is captured now; the bus is blocked while it waits.
              hold_q  <= mem[Mem_Addr];
              lat_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (lat_q == LAT_LAST) begin
            rv_q    <= 1'b1;
            rdata_q <= hold_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign M_R_Data = rdata_q;
  assign R_Valid  = rv_q;
  assign Busy     = busy_q;
  assign Err      = err_q;
  assign Err_Cnt  = cnt_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          Mem_Read;
  logic          Mem_Write;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] M_W_Data;
  logic [3:0]    Mem_BE;
  logic [DW-1:0] M_R_Data;
  logic          R_Valid;
  logic          Busy;
  logic          Err;
  logic [7:0]    Err_Cnt;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .M_W_Data(M_W_Data), .Mem_BE(Mem_BE),
    .M_R_Data(M_R_Data), .R_Valid(R_Valid), .Busy(Busy),
    .Err(Err), .Err_Cnt(Err_Cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory contents, remaining clear cycles,
  // remaining read wait, and the observable outputs after each edge.
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] m_rdata, pend;
  logic          m_rv, m_err, m_busy, model_ok = 1'b0;
  logic [7:0]    m_cnt;
  int            init_left, rwait;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                         input logic [3:0] be);
    logic [DW-1:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ok  <= 1'b1;
      m_rdata   <= '0;
      m_rv      <= 1'b0;
      m_err     <= 1'b0;
      m_cnt     <= '0;
      m_busy    <= 1'b1;
      init_left <= DEPTH;
      rwait     <= 0;
      for (int i = 0; i < DEPTH; i++) mmem[i] <= '0;
    end else begin
      m_rv  <= 1'b0;
      m_err <= 1'b0;
      if (init_left > 0) begin
        init_left <= init_left - 1;
        m_busy    <= (init_left > 1);
      end else if (rwait > 0) begin
        rwait <= rwait - 1;
        if (rwait == 1) begin
          m_rv    <= 1'b1;
          m_rdata <= pend;
          m_busy  <= 1'b0;
        end
      end else if (Mem_Read && Mem_Write) begin
        m_err <= 1'b1;
        if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
      end else if (Mem_Write) begin
        mmem[Mem_Addr] <= merge(mmem[Mem_Addr], M_W_Data, Mem_BE);
      end else if (Mem_Read) begin
        if (LAT == 1) begin
          m_rv    <= 1'b1;
          m_rdata <= mmem[Mem_Addr];
        end else begin
          pend   <= mmem[Mem_Addr];
          rwait  <= LAT - 1;
          m_busy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_rdata", M_R_Data, m_rdata);
      check("cyc_rvalid", 32'(R_Valid), 32'(m_rv));
      check("cyc_busy", 32'(Busy), 32'(m_busy));
      check("cyc_err", 32'(Err), 32'(m_err));
      check("cyc_errcnt", 32'(Err_Cnt), 32'(m_cnt));
    end
  end

  task automatic idle_inputs();
    Mem_Read = 0; Mem_Write = 0; Mem_Addr = '0; M_W_Data = '0; Mem_BE = '0;
  endtask

  // Called at the negedge where rst has just dropped.
  task automatic count_busy(output int n, output logic rv_seen);
    n = 0; rv_seen = 0;
    while (Busy && n < 1000) begin
      n++;
      if (R_Valid) rv_seen = 1;
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    Mem_Write = 1; Mem_Addr = a; M_W_Data = d; Mem_BE = be;
    @(negedge clk);
    Mem_Write = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat,
                         output logic b_after);
    Mem_Read = 1; Mem_Addr = a;
    @(negedge clk);
    Mem_Read = 0;
    b_after = Busy;
    lat = 1;
    while (!R_Valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = M_R_Data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int n, lat;
    logic rvs, b1;
    logic [DW-1:0] d;

    idle_inputs();
    rst = 1;
    // 1: reset, clear sequence, read of a cleared word
    repeat (2) @(negedge clk);
    rst = 0;
    count_busy(n, rvs);
    check("t1_busy_cycles", 32'(n), 32'd256);
    do_read(8'h05, d, lat, b1);
    check("t1_rdata", d, 32'h0);
    check("t1_lat", 32'(lat), 32'd2);

    // 2: write then read, read-after-write latency
    do_write(8'h01, 32'h0000_0010, 4'hF);
    do_read(8'h01, d, lat, b1);
    check("t2_busy_after_accept", 32'(b1), 32'd1);
    check("t2_lat", 32'(lat), 32'd2);
    check("t2_rdata", d, 32'h0000_0010);
    @(negedge clk);
    check("t2_rvalid_pulse", 32'(R_Valid), 32'd0);

    // 3: byte-enable merge
    do_write(8'h00, 32'h1122_3344, 4'hF);
    do_write(8'h00, 32'hAABB_CCDD, 4'b0101);
    do_read(8'h00, d, lat, b1);
    check("t3_rdata", d, 32'h11BB_33DD);

    // 4: conflicts and saturation
    Mem_Read = 1; Mem_Write = 1; Mem_Addr = 8'h00; M_W_Data = 32'h0000_0100; Mem_BE = 4'hF;
    @(negedge clk);
    idle_inputs();
    check("t4_err", 32'(Err), 32'd1);
    check("t4_errcnt", 32'(Err_Cnt), 32'd1);
    check("t4_rdata_held", M_R_Data, 32'h11BB_33DD);
    @(negedge clk);
    check("t4_err_pulse", 32'(Err), 32'd0);
    do_read(8'h00, d, lat, b1);
    check("t4_addr0_unchanged", d, 32'h11BB_33DD);
    Mem_Read = 1; Mem_Write = 1; Mem_Addr = 8'h00; M_W_Data = 32'h0000_0100; Mem_BE = 4'hF;
    repeat (299) @(negedge clk);
    idle_inputs();
    check("t4_errcnt_sat", 32'(Err_Cnt), 32'hFF);

    // 5: write presented while busy is dropped
    do_write(8'h02, 32'h0000_2222, 4'hF);
    Mem_Read = 1; Mem_Addr = 8'h02;
    @(negedge clk);
    Mem_Read = 0;
    check("t5_busy", 32'(Busy), 32'd1);
    Mem_Write = 1; Mem_Addr = 8'h02; M_W_Data = 32'hDEAD_BEEF; Mem_BE = 4'hF;
    @(negedge clk);
    idle_inputs();
    check("t5_rvalid", 32'(R_Valid), 32'd1);
    check("t5_rdata", M_R_Data, 32'h0000_2222);
    do_read(8'h02, d, lat, b1);
    check("t5_dropped", d, 32'h0000_2222);

    // 6: reset right after a read accept
    Mem_Read = 1; Mem_Addr = 8'h01;
    @(negedge clk);
    Mem_Read = 0;
    rst = 1;
    @(negedge clk);
    check("t6_no_rvalid", 32'(R_Valid), 32'd0);
    rst = 0;
    count_busy(n, rvs);
    check("t6_busy_cycles", 32'(n), 32'd256);
    check("t6_no_rvalid_init", 32'(rvs), 32'd0);
    check("t6_errcnt_cleared", 32'(Err_Cnt), 32'd0);
    do_read(8'h01, d, lat, b1);
    check("t6_rdata_cleared", d, 32'h0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, synchronous, single-port data memory with a request/valid handshake, per-byte write enables and a configurable read pipeline latency. It succeeds the combinational 256x32 data memory and keeps the Mem_Read / Mem_Write / Mem_Addr / M_W_Data / M_R_Data port set. It adds a hardware clear-on-reset sequencer, read/write conflict detection and an error counter. It sits between the CPU datapath's memory stage and the storage array.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words.
READ_LATENCY, 2, cycles from the read accept edge to the data-valid cycle; legal range 1..4.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
Mem_Read  in  1  read request.
Mem_Write  in  1  write request.
Mem_Addr  in  ADDR_WIDTH  word address.
M_W_Data  in  DATA_WIDTH  write data.
Mem_BE  in  DATA_WIDTH/8  byte enables; bit i selects bits [8i+7:8i].
M_R_Data  out  DATA_WIDTH  read data; holds its last value between reads.
R_Valid  out  1  one-cycle pulse marking M_R_Data valid.
Busy  out  1  high means requests are not accepted.
Err  out  1  one-cycle pulse on a read/write conflict.
Err_Cnt  out  8  saturating count of conflicts.

Behaviour:
- Reset: one clock; rst is synchronous and active-high. While rst=1: M_R_Data=0, R_Valid=0, Err=0, Err_Cnt=0, Busy=1, state=INIT, clear pointer=0. Reset overrides every other input.
- States: INIT, IDLE, READ.
- INIT:
  - Starting at the first edge with rst=0, writes zero to address 0, then 1, and so on, one word per edge.
  - After the edge that writes DEPTH-1: Busy=0, state=IDLE. Busy is therefore high for exactly DEPTH cycles after reset release.
  - All requests are ignored during INIT.
- Accept rule: a request is sampled only at an edge where Busy=0. Requests presented while Busy=1 are dropped silently: no state change, no Err.
- Write (IDLE, Mem_Write=1, Mem_Read=0):
  - Each byte i with Mem_BE[i]=1 is updated at the accept edge. Mem_BE=0 is a legal no-op.
  - Busy stays 0; back-to-back writes run one per cycle.
- Read (IDLE, Mem_Read=1, Mem_Write=0):
  - The array word is captured at the accept edge E0.
  - Read-after-write: a read accepted on the edge after a write to the same address returns the new data.
  - READ_LATENCY=1: R_Valid=1 and M_R_Data updated after E0; no Busy; back-to-back reads run one per cycle.
  - READ_LATENCY=L>1: state=READ and Busy=1 from E0 through E(L-2), i.e. for L-1 cycles. After E(L-1): R_Valid=1, M_R_Data updated, Busy=0, state=IDLE. The next request can be accepted at E(L).
  - R_Valid is exactly one cycle wide.
- Conflict (Mem_Read=1 and Mem_Write=1, Busy=0):
  - No array access; M_R_Data unchanged.
  - Err=1 for the one cycle after the edge.
  - Err_Cnt increments and saturates at 8'hFF.
- Neither request asserted: idle, outputs hold.
- Reset asserted mid-read: the read is aborted, no R_Valid is produced, and a full INIT re-runs. Memory contents are cleared again.
- Mem_Addr covers the full depth; there is no out-of-range case. Address wrap is the caller's responsibility.

Test Plan:
1. Assert rst for 2 cycles, then release -> Busy high for exactly 256 cycles; then a read of 8'h05 returns 32'h0 with R_Valid pulsed once.
2. Write 32'h0000_0010 to addr 8'h01 with BE=4'hF, then read addr 8'h01 -> Busy=1 for 1 cycle; R_Valid pulses 2 cycles after the accept edge with M_R_Data=32'h0000_0010.
3. Write 32'h1122_3344 to addr 0 with BE=4'hF, then write 32'hAABB_CCDD with BE=4'b0101, then read addr 0 -> 32'h11BB_33DD.
4. Mem_Read=Mem_Write=1, addr 0, data 32'h0000_0100 -> Err pulses for 1 cycle, Err_Cnt=1, addr 0 unchanged. Repeat 300 conflicts -> Err_Cnt=8'hFF.
5. Present a write of 32'hDEAD_BEEF to addr 8'h02 in the cycle Busy=1 after a read accept -> write dropped; a later read of addr 8'h02 returns its previous value.
6. Assert rst for 1 cycle immediately after a read accept -> no R_Valid; Busy=1 for 256 cycles after release; previously written addr 8'h01 reads 32'h0.
